flag_restore: RTL and testbench

//  Pop-side controller for the execute-stage flag stack. On RETI/POPF from decode it

---
 rtl/banff_flag_pkg.sv | 23 ++
 rtl/flag_restore.sv | 128 ++++++++++++
 tb/tb_flag_restore.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/banff_flag_pkg.sv
// Shared definitions for the execute-stage flag stack: default widths, flag bit positions
// and the pop-controller state encoding.
package banff_flag_pkg;

    localparam int unsigned FlagWidthDefault = 8;
    localparam int unsigned DepthBitsDefault = 4;

    // Status-flag bit positions within a flag word
    localparam int unsigned FlagZ = 0;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagN = 2;
    localparam int unsigned FlagV = 3;
    localparam int unsigned FlagI = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StWait  = 3'd2,
        StApply = 3'd3,
        StUflow = 3'd4
    } state_e;

endpackage

// File: rtl/flag_restore.sv
// Flag-stack pop controller: reads the top entry on RETI/POPF and merges it into the live flags
// under a mask. Define FLAG_RESTORE_PARITY_EN to add an even-parity check on stack entries.
module flag_restore
    import banff_flag_pkg::*;
#(
    parameter int unsigned FlagWidth = FlagWidthDefault,
    parameter int unsigned DepthBits = DepthBitsDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pop_req_i,
    input  logic [FlagWidth-1:0] pop_mask_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 pop_ack_o,
    input  logic [DepthBits:0]   stack_depth_i,
    output logic                 rd_en_o,
`ifdef FLAG_RESTORE_PARITY_EN
    input  logic [FlagWidth:0]   rd_data_i,
    output logic                 parity_err_o,
`else
    input  logic [FlagWidth-1:0] rd_data_i,
`endif
    output logic                 stk_pop_o,
    input  logic [FlagWidth-1:0] flags_cur_i,
    output logic                 flags_wr_en_o,
    output logic [FlagWidth-1:0] flags_wr_data_o,
    output logic                 underflow_o,
    input  logic                 underflow_clr_i
);

`ifdef FLAG_RESTORE_PARITY_EN
    localparam int unsigned EntryWidth = FlagWidth + 1;
`else
    localparam int unsigned EntryWidth = FlagWidth;
`endif

    state_e                 state_q, state_d;
    logic [FlagWidth-1:0]   mask_q, mask_d;
    logic [EntryWidth-1:0]  entry_q, entry_d;
    logic                   underflow_q, underflow_d;
    logic                   entry_ok;
    logic [FlagWidth-1:0]   payload;

    assign payload = entry_q[FlagWidth-1:0];

`ifdef FLAG_RESTORE_PARITY_EN
    // MSB holds even parity over the payload
    assign entry_ok = (entry_q[FlagWidth] == ^payload);
`else
    assign entry_ok = 1'b1;
`endif

    always_comb begin
        state_d         = state_q;
        mask_d          = mask_q;
        entry_d         = entry_q;
        busy_o          = 1'b0;
        pop_ack_o       = 1'b0;
        rd_en_o         = 1'b0;
        stk_pop_o       = 1'b0;
        flags_wr_en_o   = 1'b0;
        flags_wr_data_o = '0;
`ifdef FLAG_RESTORE_PARITY_EN
        parity_err_o    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // A flush in the same cycle drops the request outright
                if (pop_req_i && !flush_i) begin
                    mask_d  = pop_mask_i;
                    state_d = (stack_depth_i != '0) ? StRead : StUflow;
                end
            end
            StRead: begin
                busy_o  = 1'b1;
                rd_en_o = 1'b1;
                state_d = flush_i ? StIdle : StWait;
            end
            StWait: begin
                busy_o  = 1'b1;
                entry_d = rd_data_i;
                state_d = flush_i ? StIdle : StApply;
            end
            StApply: begin
                busy_o          = 1'b1;
                stk_pop_o       = 1'b1;
                pop_ack_o       = 1'b1;
                flags_wr_en_o   = entry_ok;
                flags_wr_data_o = (payload & mask_q) | (flags_cur_i & ~mask_q);
`ifdef FLAG_RESTORE_PARITY_EN
                parity_err_o    = !entry_ok;
`endif
                state_d         = StIdle;
            end
            StUflow: begin
                busy_o    = 1'b1;
                pop_ack_o = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Set takes priority over clear
    always_comb begin
        underflow_d = underflow_q;
        if (underflow_clr_i) underflow_d = 1'b0;
        if (state_q == StUflow) underflow_d = 1'b1;
    end

    assign underflow_o = underflow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            entry_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            entry_q     <= entry_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_flag_restore.sv
// Self-checking bench for flag_restore: directed scenarios plus randomized pops against a
// transaction-level model. Honors FLAG_RESTORE_PARITY_EN for the parity variant.
module tb_flag_restore;

`ifdef FLAG_RESTORE_PARITY_EN
    localparam int RdW = 9;
`else
    localparam int RdW = 8;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pop_req;
    logic [7:0]     pop_mask;
    logic           flush;
    logic           busy;
    logic           pop_ack;
    logic [4:0]     stack_depth;
    logic           rd_en;
    logic [RdW-1:0] rd_data;
    logic           stk_pop;
    logic [7:0]     flags_cur;
    logic           flags_wr_en;
    logic [7:0]     flags_wr_data;
    logic           underflow;
    logic           underflow_clr;
`ifdef FLAG_RESTORE_PARITY_EN
    logic           parity_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit uf_model = 1'b0;

    always #5 clk = ~clk;

    flag_restore dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .pop_req_i       (pop_req),
        .pop_mask_i      (pop_mask),
        .flush_i         (flush),
        .busy_o          (busy),
        .pop_ack_o       (pop_ack),
        .stack_depth_i   (stack_depth),
        .rd_en_o         (rd_en),
        .rd_data_i       (rd_data),
`ifdef FLAG_RESTORE_PARITY_EN
        .parity_err_o    (parity_err),
`endif
        .stk_pop_o       (stk_pop),
        .flags_cur_i     (flags_cur),
        .flags_wr_en_o   (flags_wr_en),
        .flags_wr_data_o (flags_wr_data),
        .underflow_o     (underflow),
        .underflow_clr_i (underflow_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-bit selection: mask bit set takes the stacked bit, else keeps the live flag
    function automatic logic [7:0] model_merge(input logic [7:0] e, input logic [7:0] m,
                                               input logic [7:0] c);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = m[b] ? e[b] : c[b];
        return r;
    endfunction

    function automatic logic [RdW-1:0] make_rd(input logic [7:0] e, input bit bad);
`ifdef FLAG_RESTORE_PARITY_EN
        logic p;
        p = (($countones(e) % 2) == 1) ^ bad;
        return {p, e};
`else
        return e;
`endif
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " rd_en"}, 32'(rd_en), 0);
        check({tag, " stk_pop"}, 32'(stk_pop), 0);
        check({tag, " pop_ack"}, 32'(pop_ack), 0);
        check({tag, " wr_en"}, 32'(flags_wr_en), 0);
`ifdef FLAG_RESTORE_PARITY_EN
        check({tag, " parity_err"}, 32'(parity_err), 0);
`endif
    endtask

    // One pop request issued in cycle 0, observed for cycles 1..4.
    // flush_at: cycle in which flush is held; clr: underflow_clr held in cycle 1.
    task automatic run_pop(input logic [4:0] depth, input logic [7:0] mask, input logic [7:0] entry,
                           input logic [7:0] cur, input int flush_at, input bit clr, input bit bad);
        logic [7:0] exp_data;
        bit eb, er, ep, ea, ew, ee, aborted;
        exp_data = model_merge(entry, mask, cur);
        aborted  = (depth != 0) && (flush_at == 1 || flush_at == 2);
        pop_req = 1'b1; pop_mask = mask; stack_depth = depth; flags_cur = cur;
        flush = 1'b0; underflow_clr = 1'b0;
        rd_data = make_rd(8'($urandom), 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (depth == 0 && k == 2) uf_model = 1'b1;
            else if (clr && k == 2) uf_model = 1'b0;
            // A stray request while busy must be ignored
            pop_req       = (k == 1);
            pop_mask      = 8'($urandom);
            if (k == 1) stack_depth = 5'd0;
            flush         = (k == flush_at);
            underflow_clr = clr && (k == 1);
            rd_data       = (k == 2) ? make_rd(entry, bad) : make_rd(8'($urandom), 1'b0);
            {eb, er, ep, ea, ew, ee} = '0;
            if (depth == 0) begin
                if (k == 1) begin eb = 1; ea = 1; end
            end else begin
                if (k == 1) begin eb = 1; er = 1; end
                if (k == 2 && flush_at != 1) eb = 1;
                if (k == 3 && !aborted) begin
                    eb = 1; ep = 1; ea = 1; ew = !bad; ee = bad;
                end
            end
            check($sformatf("k%0d busy", k), 32'(busy), 32'(eb));
            check($sformatf("k%0d rd_en", k), 32'(rd_en), 32'(er));
            check($sformatf("k%0d stk_pop", k), 32'(stk_pop), 32'(ep));
            check($sformatf("k%0d pop_ack", k), 32'(pop_ack), 32'(ea));
            check($sformatf("k%0d wr_en", k), 32'(flags_wr_en), 32'(ew));
            check($sformatf("k%0d underflow", k), 32'(underflow), 32'(uf_model));
            if (ew) check($sformatf("k%0d wr_data", k), 32'(flags_wr_data), 32'(exp_data));
`ifdef FLAG_RESTORE_PARITY_EN
            check($sformatf("k%0d parity_err", k), 32'(parity_err), 32'(ee));
`endif
        end
        pop_req = 1'b0; flush = 1'b0; underflow_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pop_req = 1'b0; pop_mask = '0; flush = 1'b0; stack_depth = '0;
        rd_data = '0; flags_cur = '0; underflow_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        check("reset wr_data", 32'(flags_wr_data), 0);
        check("reset underflow", 32'(underflow), 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check_quiet("idle");

        // Full restore, partial mask, empty mask
        run_pop(5'd3, 8'hFF, 8'hA5, 8'h0F, 0, 1'b0, 1'b0);
        run_pop(5'd2, 8'h3C, 8'hF0, 8'h0F, 0, 1'b0, 1'b0);
        run_pop(5'd5, 8'h00, 8'h5A, 8'hC3, 0, 1'b0, 1'b0);
        run_pop(5'd16, 8'h81, 8'h7E, 8'h81, 0, 1'b0, 1'b0);

        // Underflow, clear, then clear coinciding with a new underflow
        run_pop(5'd0, 8'hFF, 8'h00, 8'h00, 0, 1'b0, 1'b0);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        uf_model = 1'b0;
        check("uf clr", 32'(underflow), 0);
        run_pop(5'd0, 8'h12, 8'h00, 8'h00, 0, 1'b1, 1'b0);

        // Flush in WAIT, flush in READ, flush in APPLY (ignored)
        run_pop(5'd3, 8'hFF, 8'h11, 8'h22, 2, 1'b0, 1'b0);
        run_pop(5'd3, 8'hFF, 8'h33, 8'h44, 1, 1'b0, 1'b0);
        run_pop(5'd3, 8'hF0, 8'h55, 8'h66, 3, 1'b0, 1'b0);

        // Flush together with a request in IDLE drops it
        pop_req = 1'b1; flush = 1'b1; stack_depth = 5'd3;
        step();
        pop_req = 1'b0; flush = 1'b0;
        check_quiet("flush+req");
        step();
        check_quiet("flush+req next");

        // Async reset while in WAIT
        pop_req = 1'b1; pop_mask = 8'hFF; stack_depth = 5'd3;
        step();
        pop_req = 1'b0;
        step();
        check("pre-reset busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_quiet("async reset");
        check("async reset underflow", 32'(underflow), 0);
        uf_model = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        check_quiet("post-reset");
        run_pop(5'd1, 8'hFF, 8'hC6, 8'h39, 0, 1'b0, 1'b0);

`ifdef FLAG_RESTORE_PARITY_EN
        run_pop(5'd4, 8'hFF, 8'h01, 8'h00, 0, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [4:0] d;
            bit         bad_p;
            d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 16));
`ifdef FLAG_RESTORE_PARITY_EN
            bad_p = ($urandom_range(0, 3) == 0);
`else
            bad_p = 1'b0;
`endif
            run_pop(d, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 4) == 0), bad_p);
            if ($urandom_range(0, 2) == 0) begin
                step();
                check_quiet("rand gap");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
